// File: rtl/pixel_shift_pkg.sv
// Purpose: shared FSM state type, accumulator-width function and channel-lane pack/unpack helpers.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
// Lane helpers work on a BUS_MAX-bit carrier with lanes up to LANE_MAX bits; CHANNELS*ACC_W must fit in BUS_MAX.
package pixel_shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int LANE_MAX = 32;
    localparam int BUS_MAX  = 128;

    // Summing N_SHIFTS samples of PIX_W bits needs log2(N_SHIFTS) extra bits.
    function automatic int acc_width(input int pix_w, input int n_shifts);
        return pix_w + $clog2(n_shifts);
    endfunction

    // Extract lane 'lane' of width 'w', zero-extended to LANE_MAX bits.
    function automatic logic [LANE_MAX-1:0] lane_get(input logic [BUS_MAX-1:0] bus,
                                                     input int lane, input int w);
        return LANE_MAX'(bus >> (lane * w)) & ((LANE_MAX'(1) << w) - LANE_MAX'(1));
    endfunction

    // Replace lane 'lane' of width 'w' with the low w bits of val.
    function automatic logic [BUS_MAX-1:0] lane_put(input logic [BUS_MAX-1:0] bus,
                                                    input int lane, input int w,
                                                    input logic [LANE_MAX-1:0] val);
        logic [BUS_MAX-1:0] mask;
        mask = ((BUS_MAX'(1) << w) - BUS_MAX'(1)) << (lane * w);
        return (bus & ~mask) | ((BUS_MAX'(val) << (lane * w)) & mask);
    endfunction

endpackage

// File: rtl/pixel_shift_acc_mem.sv
// Purpose: TILE_PIX-entry accumulator array, one CHANNELS*ACC_W word per pixel.
// Latency: rmw read combinational; write lands next edge; drain read registered (1 cycle).
// Backpressure: none; rd_en gates the drain register so the caller can hold it.
// Ports: clock/reset_n; wr_en/wr_addr/wr_data write; rmw_addr->rmw_data async read; rd_en/rd_addr->rd_data registered read.
module pixel_shift_acc_mem #(
    parameter  int TILE_PIX = 16,
    parameter  int WIDTH    = 30,
    localparam int AW       = $clog2(TILE_PIX)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rmw_addr,
    output logic [WIDTH-1:0] rmw_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    // No reset on the array: the first sub-frame of a tile overwrites every entry.
    logic [WIDTH-1:0] mem [TILE_PIX];
    logic [WIDTH-1:0] rd_q;

    assign rmw_data = mem[rmw_addr];
    assign rd_data  = rd_q;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_q <= '0;
        end else if (rd_en) begin
            rd_q <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/pixel_shift_accumulator.sv
// Purpose: accumulate N_SHIFTS sub-frames of a TILE_PIX-pixel tile per channel, then stream the averaged tile.
// Latency: first output beat 1 cycle after entering DRAIN, then 1 pixel/cycle.
// Backpressure: in_ready high only in ACCUM; output register holds data/last while out_valid && !out_ready.
// Ports: start/abort control; in_valid/in_ready/in_data input stream; out_valid/out_ready/out_data/out_last
//        output stream; busy (state != IDLE); tile_done pulse after the last output beat is accepted.
// Build option: define PIXSHIFT_ROUND_EN for round-half-up averaging with saturation; otherwise truncating.
module pixel_shift_accumulator
    import pixel_shift_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int PIX_W    = 8,
    parameter int N_SHIFTS = 4,
    parameter int TILE_PIX = 16
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*PIX_W-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS*PIX_W-1:0] out_data,
    output logic                      out_last,
    output logic                      busy,
    output logic                      tile_done
);

    localparam int ACC_W = acc_width(PIX_W, N_SHIFTS);
    localparam int SW    = $clog2(N_SHIFTS);
    localparam int AW    = $clog2(TILE_PIX);
    localparam int DW    = CHANNELS * PIX_W;
    localparam int MW    = CHANNELS * ACC_W;
    localparam logic [AW-1:0] LAST_ADDR  = AW'(TILE_PIX - 1);
    localparam logic [SW-1:0] LAST_SHIFT = SW'(N_SHIFTS - 1);

    state_t         state, state_nxt;
    logic [AW-1:0]  addr;
    logic [AW-1:0]  addr_inc;
    logic [SW-1:0]  shift;
    logic           accept, tile_end, drain_load, drain_fin;
    logic [MW-1:0]  rmw_data, wr_data, rd_data;
    logic [BUS_MAX-1:0]  wr_bus, out_bus;
    logic [LANE_MAX-1:0] smp, accv, sumv, drn, pixv;
    logic           unused_bus_bits;

    assign in_ready = (state == ACCUM);
    assign busy     = (state != IDLE);
    assign addr_inc = (addr == LAST_ADDR) ? '0 : addr + AW'(1);

    // abort beats any handshake in the same cycle, so nothing is written.
    assign accept     = in_valid && in_ready && !abort;
    assign tile_end   = accept && (shift == LAST_SHIFT) && (addr == LAST_ADDR);
    assign drain_fin  = (state == DRAIN) && out_valid && out_ready && out_last;
    // Load the output register when it is empty or being consumed, until the last pixel is in it.
    assign drain_load = (state == DRAIN) && !abort && (!out_valid || out_ready)
                        && !(out_valid && out_last);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start)     state_nxt = ACCUM;
                ACCUM:   if (tile_end)  state_nxt = DRAIN;
                DRAIN:   if (drain_fin) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // addr is the write pointer in ACCUM and the read pointer in DRAIN; it wraps to 0
    // at the end of each phase, so DRAIN starts at pixel 0 without an explicit clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr      <= '0;
            shift     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            tile_done <= 1'b0;
        end else begin
            tile_done <= 1'b0;
            if (abort) begin
                addr      <= '0;
                shift     <= '0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                if (state == IDLE && start) begin
                    addr  <= '0;
                    shift <= '0;
                end
                if (accept) begin
                    addr <= addr_inc;
                    if (addr == LAST_ADDR) begin
                        shift <= shift + SW'(1);
                    end
                end
                if (drain_load) begin
                    addr      <= addr_inc;
                    out_valid <= 1'b1;
                    out_last  <= (addr == LAST_ADDR);
                end else if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
                if (drain_fin) begin
                    tile_done <= 1'b1;
                end
            end
        end
    end

    pixel_shift_acc_mem #(
        .TILE_PIX (TILE_PIX),
        .WIDTH    (MW)
    ) u_acc_mem (
        .clock    (clock),
        .reset_n  (reset_n),
        .wr_en    (accept),
        .wr_addr  (addr),
        .wr_data  (wr_data),
        .rmw_addr (addr),
        .rmw_data (rmw_data),
        .rd_en    (drain_load),
        .rd_addr  (addr),
        .rd_data  (rd_data)
    );

    // Read-modify-write: sub-frame 0 overwrites, later sub-frames add.
    always_comb begin
        wr_bus = '0;
        smp    = '0;
        accv   = '0;
        sumv   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            smp    = lane_get(BUS_MAX'(in_data), c, PIX_W);
            accv   = lane_get(BUS_MAX'(rmw_data), c, ACC_W);
            sumv   = (shift == '0) ? smp : accv + smp;
            wr_bus = lane_put(wr_bus, c, ACC_W, sumv);
        end
    end
    assign wr_data = wr_bus[MW-1:0];

`ifdef PIXSHIFT_ROUND_EN
    localparam logic [LANE_MAX-1:0] PIX_MAX = LANE_MAX'((1 << PIX_W) - 1);
`endif

    // Averaging on the registered drain word; out_data is stable whenever rd_data is held.
    always_comb begin
        out_bus = '0;
        drn     = '0;
        pixv    = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            drn = lane_get(BUS_MAX'(rd_data), c, ACC_W);
`ifdef PIXSHIFT_ROUND_EN
            // Only ACC_W+1 bits of this sum are ever non-zero.
            pixv = (drn + LANE_MAX'(N_SHIFTS / 2)) >> SW;
            if (pixv > PIX_MAX) begin
                pixv = PIX_MAX;
            end
`else
            pixv = drn >> SW;
`endif
            out_bus = lane_put(out_bus, c, PIX_W, pixv);
        end
    end
    assign out_data = out_bus[DW-1:0];

    assign unused_bus_bits = ^{wr_bus[BUS_MAX-1:MW], out_bus[BUS_MAX-1:DW]};

endmodule

// File: tb/tb_pixel_shift_accumulator.sv
`timescale 1ns/1ps
module tb_pixel_shift_accumulator;

    localparam int CH = 3;
    localparam int PW = 8;
    localparam int NS = 4;
    localparam int TP = 16;
    localparam int DW = CH * PW;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          tile_done;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] stim [NS][TP];

    pixel_shift_accumulator #(
        .CHANNELS (CH),
        .PIX_W    (PW),
        .N_SHIFTS (NS),
        .TILE_PIX (TP)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .tile_done (tile_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference average of pixel p over the stored sub-frames.
    function automatic logic [DW-1:0] exp_pix(input int p);
        logic [DW-1:0] r;
        int sum;
        int v;
        r = '0;
        for (int c = 0; c < CH; c++) begin
            sum = 0;
            for (int k = 0; k < NS; k++) begin
                sum += int'(stim[k][p][c*PW +: PW]);
            end
`ifdef PIXSHIFT_ROUND_EN
            v = (sum + NS / 2) / NS;
            if (v > 255) v = 255;
`else
            v = sum / NS;
`endif
            r[c*PW +: PW] = PW'(v);
        end
        return r;
    endfunction

    // All tasks start and end just after a falling edge.
    task automatic start_tile();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input int gap);
        int guard;
        repeat (gap) @(negedge clock);
        in_valid = 1'b1;
        in_data  = d;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        check("send_ready", 32'(in_ready), 32'(1));
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic send_tile(input int max_gap);
        for (int k = 0; k < NS; k++) begin
            for (int p = 0; p < TP; p++) begin
                send_beat(stim[k][p], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
            end
        end
    endtask

    task automatic recv_tile(input int stall_at);
        int i;
        int idle;
        logic [DW-1:0] held;
        i = 0;
        idle = 0;
        out_ready = 1'b1;
        while (i < TP && idle < 100) begin
            if (out_valid) begin
                if (i == stall_at) begin
                    out_ready = 1'b0;
                    held = out_data;
                    repeat (3) begin
                        @(negedge clock);
                        check("stall_valid", 32'(out_valid), 32'(1));
                        check("stall_data", 32'(out_data), 32'(held));
                    end
                    out_ready = 1'b1;
                end
                check($sformatf("pix%0d_data", i), 32'(out_data), 32'(exp_pix(i)));
                check($sformatf("pix%0d_last", i), 32'(out_last), 32'(i == TP - 1));
                i++;
            end else begin
                idle++;
            end
            @(negedge clock);
        end
        check("beats", i, TP);
        check("drain_idle", idle, 1);
        check("done_pulse", 32'(tile_done), 32'(1));
        check("valid_after", 32'(out_valid), 32'(0));
        check("busy_after", 32'(busy), 32'(0));
        @(negedge clock);
        check("done_width", 32'(tile_done), 32'(0));
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clock);
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_out_last", 32'(out_last), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_tile_done", 32'(tile_done), 32'(0));
        reset_n = 1'b1;
        @(negedge clock);

        // Tile 1: sub-frame k carries 10*(k+1) everywhere -> 25; start pulse mid-tile ignored
        for (int k = 0; k < NS; k++)
            for (int p = 0; p < TP; p++)
                stim[k][p] = {3{8'(10 * (k + 1))}};
        start_tile();
        check("t1_busy", 32'(busy), 32'(1));
        check("t1_in_ready", 32'(in_ready), 32'(1));
        for (int p = 0; p < 5; p++) send_beat(stim[0][p], 0);
        start_tile();
        check("t1_busy_after_start", 32'(busy), 32'(1));
        for (int p = 5; p < TP; p++) send_beat(stim[0][p], 0);
        for (int k = 1; k < NS; k++)
            for (int p = 0; p < TP; p++)
                send_beat(stim[k][p], 0);
        recv_tile(-1);
        check("t1_pix_const", 32'(exp_pix(0)), 32'(24'h191919));

        // Tile 2: full scale, no wrap
        for (int k = 0; k < NS; k++)
            for (int p = 0; p < TP; p++)
                stim[k][p] = 24'hFFFFFF;
        start_tile();
        send_tile(0);
        recv_tile(-1);

        // Tile 3: ch0 1,1,1,2 (sum 5), ch1 1,2,2,2 (sum 7, rounding changes it), ch2 per-pixel
        for (int k = 0; k < NS; k++)
            for (int p = 0; p < TP; p++)
                stim[k][p] = {8'(p + ((k == 3) ? 1 : 0)), 8'((k == 0) ? 1 : 2), 8'((k == 3) ? 2 : 1)};
        start_tile();
        send_tile(0);
        recv_tile(-1);

        // Tile 4: random data, random input gaps, 3-cycle stall mid-drain
        for (int k = 0; k < NS; k++)
            for (int p = 0; p < TP; p++)
                stim[k][p] = 24'($urandom);
        start_tile();
        send_tile(2);
        recv_tile(5);

        // Abort after 20 accepted beats, with a beat offered on the abort cycle
        start_tile();
        for (int b = 0; b < 20; b++) send_beat(stim[b / TP][b % TP], 0);
        abort = 1'b1;
        in_valid = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        in_valid = 1'b0;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_in_ready", 32'(in_ready), 32'(0));
        check("abort_out_valid", 32'(out_valid), 32'(0));
        repeat (3) begin
            @(negedge clock);
            check("abort_no_done", 32'(tile_done), 32'(0));
        end
        start = 1'b1;
        abort = 1'b1;
        @(negedge clock);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle", 32'(busy), 32'(0));
        for (int k = 0; k < NS; k++)
            for (int p = 0; p < TP; p++)
                stim[k][p] = {3{8'd7}};
        start_tile();
        send_tile(0);
        recv_tile(-1);

        // Reset during DRAIN, then a fresh tile
        for (int k = 0; k < NS; k++)
            for (int p = 0; p < TP; p++)
                stim[k][p] = {8'(3 * p + k), 8'(200 - p), 8'(16 * k + p)};
        start_tile();
        send_tile(0);
        out_ready = 1'b1;
        repeat (4) @(negedge clock);
        check("mid_drain_valid", 32'(out_valid), 32'(1));
        reset_n = 1'b0;
        #1;
        check("rst_drain_valid", 32'(out_valid), 32'(0));
        check("rst_drain_busy", 32'(busy), 32'(0));
        check("rst_drain_last", 32'(out_last), 32'(0));
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        check("post_rst_idle", 32'(busy), 32'(0));
        check("post_rst_valid", 32'(out_valid), 32'(0));
        for (int k = 0; k < NS; k++)
            for (int p = 0; p < TP; p++)
                stim[k][p] = {8'(p * 5), 8'(k * 60 + 3), 8'(255 - 4 * p)};
        start_tile();
        send_tile(1);
        recv_tile(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
